// File: rtl/fir_folded.sv
// Folded FIR: one signed MAC reused across TAPS taps, circular sample history,
// writable coefficient bank. Optional saturation counter via FIR_FOLDED_SAT_CNT_EN.
module fir_folded #(
  parameter  int unsigned TAPS      = 64,
  parameter  int unsigned DATA_W    = 16,
  parameter  int unsigned COEF_W    = 16,
  parameter  int unsigned OUT_SHIFT = 15,
  localparam int unsigned AW        = $clog2(TAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_sample,
  input  logic              coef_wr_en,
  input  logic [AW-1:0]     coef_wr_addr,
  input  logic [COEF_W-1:0] coef_wr_data,
  output logic              coef_wr_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sample,
  output logic              busy
`ifdef FIR_FOLDED_SAT_CNT_EN
  ,
  output logic [15:0]       sat_count
`endif
);

  localparam int unsigned ACC_W  = DATA_W + COEF_W + $clog2(TAPS);
  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned RW     = ACC_W + 1;
  localparam int unsigned CW     = $clog2(TAPS + 1);
  localparam int unsigned RND_SH = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;

  localparam logic signed [RW-1:0] RND  = (OUT_SHIFT > 0) ? (RW'(1) << RND_SH) : '0;
  localparam logic signed [RW-1:0] MAXV = RW'({(DATA_W-1){1'b1}});
  localparam logic signed [RW-1:0] MINV = ~MAXV;

  typedef enum logic [1:0] {CLEAR, IDLE, MAC, OUT} state_t;

  state_t state, state_d;

  logic signed [DATA_W-1:0] hist [TAPS];
  logic signed [COEF_W-1:0] coef [TAPS];

  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            rd_ptr;
  logic [AW-1:0]            clr_idx;
  logic [CW-1:0]            mac_cnt;
  logic signed [DATA_W-1:0] x_q;
  logic signed [COEF_W-1:0] h_q;
  logic signed [ACC_W-1:0]  acc;

  logic                     accept;
  logic                     coef_wr_ok;
  logic                     in_ready_d;
  logic                     busy_d;
  logic                     out_valid_d;
  logic                     load_res;
  logic                     coef_wr_err_d;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [RW-1:0]     acc_rnd;
  logic signed [RW-1:0]     acc_shr;
  logic                     sat_hi;
  logic                     sat_lo;
  logic [DATA_W-1:0]        res_d;

  // Next state and next values of registered outputs
  always_comb begin
    state_d       = state;
    accept        = in_valid && in_ready;
    coef_wr_ok    = 1'b0;
    case (state)
      CLEAR: if (clr_idx == AW'(TAPS - 1)) state_d = IDLE;
      IDLE: begin
        coef_wr_ok = coef_wr_en && (32'(coef_wr_addr) < TAPS);
        if (accept) state_d = MAC;
      end
      MAC:   if (mac_cnt == CW'(TAPS)) state_d = OUT;
      OUT:   if (out_valid && out_ready) state_d = IDLE;
      default: state_d = CLEAR;
    endcase
    in_ready_d    = (state_d == IDLE);
    busy_d        = (state_d != IDLE);
    // OUT holds one settle cycle while the final accumulate lands, then presents
    out_valid_d   = (state == OUT) && (state_d == OUT);
    load_res      = (state == OUT) && !out_valid;
    coef_wr_err_d = coef_wr_en && (state != IDLE);
  end

  // Product, rounding (half toward +inf) and saturation
  always_comb begin
    prod     = x_q * h_q;
    prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    acc_rnd  = {acc[ACC_W-1], acc} + RND;
    acc_shr  = acc_rnd >>> OUT_SHIFT;
    sat_hi   = acc_shr > MAXV;
    sat_lo   = acc_shr < MINV;
    if (sat_hi)      res_d = MAXV[DATA_W-1:0];
    else if (sat_lo) res_d = MINV[DATA_W-1:0];
    else             res_d = acc_shr[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CLEAR;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_sample  <= '0;
      coef_wr_err <= 1'b0;
      busy        <= 1'b1;
    end else begin
      state       <= state_d;
      in_ready    <= in_ready_d;
      out_valid   <= out_valid_d;
      coef_wr_err <= coef_wr_err_d;
      busy        <= busy_d;
      if (load_res) out_sample <= res_d;
    end
  end

  // History, coefficient bank and MAC datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      clr_idx <= '0;
      mac_cnt <= '0;
      x_q     <= '0;
      h_q     <= '0;
      acc     <= '0;
    end else begin
      case (state)
        CLEAR: begin
          hist[clr_idx] <= '0;
          coef[clr_idx] <= '0;
          clr_idx       <= clr_idx + 1'b1;
        end
        IDLE: begin
          if (coef_wr_ok) coef[coef_wr_addr] <= coef_wr_data;
          if (accept) begin
            hist[wr_ptr] <= in_sample;
            rd_ptr       <= wr_ptr;
            mac_cnt      <= '0;
            acc          <= '0;
          end
        end
        MAC: begin
          // Reads run one cycle ahead of the accumulate
          if (mac_cnt != CW'(TAPS)) begin
            x_q    <= hist[rd_ptr];
            h_q    <= coef[mac_cnt[AW-1:0]];
            rd_ptr <= (rd_ptr == '0) ? AW'(TAPS - 1) : rd_ptr - 1'b1;
          end
          if (mac_cnt != '0) acc <= acc + prod_ext;
          if (mac_cnt == CW'(TAPS))
            wr_ptr <= (wr_ptr == AW'(TAPS - 1)) ? '0 : wr_ptr + 1'b1;
          mac_cnt <= mac_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef FIR_FOLDED_SAT_CNT_EN
  // Counts saturated results as they are presented; sticks at all-ones
  always_ff @(posedge clk) begin
    if (rst) sat_count <= '0;
    else if (load_res && (sat_hi || sat_lo) && (sat_count != 16'hFFFF))
      sat_count <= sat_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fir_folded.sv
// Bench for fir_folded: two instances (OUT_SHIFT 0 and 15) share stimulus and
// are checked against a convolution model; sat_count checked when FIR_FOLDED_SAT_CNT_EN.
module tb_fir_folded;

  localparam int TAPS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_sample = '0;
  logic        coef_wr_en = 1'b0;
  logic [1:0]  coef_wr_addr = '0;
  logic [15:0] coef_wr_data = '0;
  logic        out_ready = 1'b0;

  logic        a_in_ready, a_coef_wr_err, a_out_valid, a_busy;
  logic [15:0] a_out_sample;
  logic        b_in_ready, b_coef_wr_err, b_out_valid, b_busy;
  logic [15:0] b_out_sample;
`ifdef FIR_FOLDED_SAT_CNT_EN
  logic [15:0] a_sat_count, b_sat_count;
`endif

  int checks = 0;
  int errors = 0;

  int coef_m [TAPS];
  int hist_m [$];
  int sat_m  [2];

  always #5 clk = ~clk;

  fir_folded #(.TAPS(TAPS), .DATA_W(16), .COEF_W(16), .OUT_SHIFT(0)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_sample(in_sample),
    .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
    .coef_wr_err(a_coef_wr_err), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_sample(a_out_sample), .busy(a_busy)
`ifdef FIR_FOLDED_SAT_CNT_EN
    , .sat_count(a_sat_count)
`endif
  );

  fir_folded #(.TAPS(TAPS), .DATA_W(16), .COEF_W(16), .OUT_SHIFT(15)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_sample(in_sample),
    .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
    .coef_wr_err(b_coef_wr_err), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_sample(b_out_sample), .busy(b_busy)
`ifdef FIR_FOLDED_SAT_CNT_EN
    , .sat_count(b_sat_count)
`endif
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // y[n] = sum_k h[k]*x[n-k], then round half up after the shift and clamp to 16 bits
  function automatic int model_out(input int sh, output bit sat);
    longint acc;
    acc = 0;
    for (int k = 0; k < TAPS; k++)
      if (k < hist_m.size()) acc += longint'(coef_m[k]) * longint'(hist_m[k]);
    if (sh > 0) acc += longint'(1) << (sh - 1);
    acc = acc >>> sh;
    sat = 1'b1;
    if (acc > 32767)  return 32767;
    if (acc < -32768) return -32768;
    sat = 1'b0;
    return int'(acc);
  endfunction

  task automatic model_clear();
    hist_m.delete();
    for (int k = 0; k < TAPS; k++) coef_m[k] = 0;
    sat_m[0] = 0;
    sat_m[1] = 0;
  endtask

  task automatic do_reset();
    int n;
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; coef_wr_en = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    chk("rst_in_ready", a_in_ready, 0);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_sample_a", $signed(a_out_sample), 0);
    chk("rst_out_sample_b", $signed(b_out_sample), 0);
    chk("rst_wr_err", a_coef_wr_err, 0);
    chk("rst_busy_a", a_busy, 1);
    chk("rst_busy_b", b_busy, 1);
`ifdef FIR_FOLDED_SAT_CNT_EN
    chk("rst_sat_count", b_sat_count, 0);
`endif
    n = 0;
    while (a_in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("clear_cycles", n, TAPS);
    chk("clear_b_in_ready", b_in_ready, 1);
    chk("idle_busy", a_busy, 0);
  endtask

  task automatic wr_coef(input int k, input int v);
    logic signed [15:0] t;
    @(negedge clk);
    coef_wr_en = 1'b1; coef_wr_addr = 2'(k); coef_wr_data = 16'(v);
    @(negedge clk);
    coef_wr_en = 1'b0;
    t = 16'(v);
    coef_m[k] = int'(t);
    chk("wr_err_idle", a_coef_wr_err, 0);
  endtask

  task automatic send(input int x, input int stall, input bit drop_wr,
                      input bit same_wr, input int sw_k, input int sw_v);
    int n, ea, eb;
    bit sa, sb;
    logic signed [15:0] xs, t;
    n = 0;
    while (a_in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("in_ready_wait", a_in_ready, 1);
    xs = 16'(x);
    in_sample = xs; in_valid = 1'b1;
    if (same_wr) begin coef_wr_en = 1'b1; coef_wr_addr = 2'(sw_k); coef_wr_data = 16'(sw_v); end
    @(posedge clk);
    if (same_wr) begin t = 16'(sw_v); coef_m[sw_k] = int'(t); end
    hist_m.push_front(int'(xs));
    if (hist_m.size() > TAPS) void'(hist_m.pop_back());
    ea = model_out(0, sa);
    eb = model_out(15, sb);
    @(negedge clk);
    in_valid = 1'b0; coef_wr_en = 1'b0; in_sample = 16'($urandom);
    chk("mac_busy", a_busy, 1);
    chk("mac_in_ready", a_in_ready, 0);
    n = 0;
    while (a_out_valid !== 1'b1 && n < 40) begin
      if (drop_wr && n == 2) begin
        coef_wr_en = 1'b1; coef_wr_addr = 2'($urandom); coef_wr_data = 16'($urandom);
      end
      @(negedge clk); n++;
      if (drop_wr && n == 3) begin
        coef_wr_en = 1'b0;
        chk("drop_err_pulse_a", a_coef_wr_err, 1);
        chk("drop_err_pulse_b", b_coef_wr_err, 1);
      end
      if (drop_wr && n == 4) chk("drop_err_clear", a_coef_wr_err, 0);
    end
    chk("latency", n, TAPS + 2);
    chk("b_out_valid", b_out_valid, 1);
    chk("out_a", $signed(a_out_sample), ea);
    chk("out_b", $signed(b_out_sample), eb);
`ifdef FIR_FOLDED_SAT_CNT_EN
    sat_m[0] += int'(sa);
    sat_m[1] += int'(sb);
    chk("sat_count_a", a_sat_count, sat_m[0]);
    chk("sat_count_b", b_sat_count, sat_m[1]);
`endif
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1; in_sample = 16'($urandom);
      @(negedge clk);
      chk("stall_valid", a_out_valid, 1);
      chk("stall_in_ready", a_in_ready, 0);
      chk("stall_hold_a", $signed(a_out_sample), ea);
      chk("stall_hold_b", $signed(b_out_sample), eb);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("hs_out_valid_a", a_out_valid, 0);
    chk("hs_out_valid_b", b_out_valid, 0);
    chk("hs_in_ready", a_in_ready, 1);
  endtask

  task automatic reset_mid_mac();
    int n;
    bit ov;
    n = 0;
    while (a_in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    in_sample = 16'(1); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    chk("midrst_out_valid", a_out_valid, 0);
    chk("midrst_in_ready", a_in_ready, 0);
    chk("midrst_busy", a_busy, 1);
    n = 0; ov = 1'b0;
    while (a_in_ready !== 1'b1 && n < 100) begin
      @(negedge clk); n++;
      if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) ov = 1'b1;
    end
    chk("midrst_clear_cycles", n, TAPS);
    chk("midrst_no_valid", ov, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int x, v;
    do_reset();

    // Impulse through h = {1,2,3,4}
    for (int k = 0; k < TAPS; k++) wr_coef(k, k + 1);
    send(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) send(0, 0, 0, 0, 0, 0);

    // Backpressure with input offered during the stall
    send(1000, 10, 0, 0, 0, 0);

    // Dropped write during MAC, then next sample still uses old bank
    send(-7, 0, 1, 0, 0, 0);
    send(300, 2, 0, 0, 0, 0);

    // Rounding: 0.5 rounds up
    do_reset();
    wr_coef(0, 16384);
    send(1, 0, 0, 0, 0, 0);
    send(-1, 0, 0, 0, 0, 0);

    // Positive and negative saturation
    do_reset();
    for (int k = 0; k < TAPS; k++) wr_coef(k, 32767);
    for (int i = 0; i < 4; i++) send(32767, 0, 0, 0, 0, 0);
    do_reset();
    for (int k = 0; k < TAPS; k++) wr_coef(k, 32767);
    for (int i = 0; i < 4; i++) send(-32768, 0, 0, 0, 0, 0);

    // Reset mid-MAC, then impulse sees all-zero bank
    do_reset();
    for (int k = 0; k < TAPS; k++) wr_coef(k, k + 5);
    send(11, 0, 0, 0, 0, 0);
    reset_mid_mac();
    send(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) send(0, 0, 0, 0, 0, 0);

    // Randomized traffic with coefficient updates, incl. write coincident with accept
    do_reset();
    for (int k = 0; k < TAPS; k++) begin
      v = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 64)) - 32 : int'($urandom);
      wr_coef(k, v);
    end
    for (int i = 0; i < 24; i++) begin
      x = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 200)) - 100 : int'($urandom);
      v = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 64)) - 32 : int'($urandom);
      if ($urandom_range(0, 4) == 0) wr_coef(int'($urandom_range(0, TAPS - 1)), v);
      send(x, int'($urandom_range(0, 3)), 1'($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 3) == 0), int'($urandom_range(0, TAPS - 1)), v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
